wino_f23_stream: RTL

//  Streaming, parametrised Winograd F(2,3) 1-D convolution engine: successor to the fixed-filter wc block.

---
 rtl/wino_f23_if.sv | 22 ++
 rtl/wino_f23_stream.sv | 93 +++++++++
 2 files changed

// File: rtl/wino_f23_if.sv
// wino_f23_if: tile/filter/result handshake bundle for the Winograd F(2,3) stream engine.
interface wino_f23_if #(parameter int DW = 10, parameter int GW = 10, parameter int OW = 10);
    logic            in_valid;
    logic            in_ready;
    logic [4*DW-1:0] in_d;
    logic            flt_load;
    logic [3*GW-1:0] flt_g;
    logic            flt_ready;
    logic            out_valid;
    logic            out_ready;
    logic [2*OW-1:0] out_z;
    logic            busy;
    logic            ovf;
    modport master (
        output in_valid, in_d, flt_load, flt_g, out_ready,
        input  in_ready, flt_ready, out_valid, out_z, busy, ovf
    );
    modport slave (
        input  in_valid, in_d, flt_load, flt_g, out_ready,
        output in_ready, flt_ready, out_valid, out_z, busy, ovf
    );
endinterface

// File: rtl/wino_f23_stream.sv
// wino_f23_stream: 3-stage Winograd F(2,3) 1-D conv engine with runtime filter and valid/ready backpressure.
// Define SATURATE_EN to clamp outputs to OW bits and raise the sticky ovf flag; otherwise outputs wrap.
module wino_f23_stream #(
    parameter int DW = 10,
    parameter int GW = 10,
    parameter int OW = 10
) (
    input logic       clk,
    input logic       rst,
    wino_f23_if.slave s
);
    localparam int TW = DW + 1;
    localparam int FW = GW + 2;
    localparam int MW = DW + GW + 3;
    localparam int SW = DW + GW + 5;
    logic signed [DW-1:0] d [4];
    logic signed [GW-1:0] f [3];
    logic signed [TW-1:0] tn [4];
    logic signed [TW-1:0] t [4];
    logic signed [FW-1:0] g [4];
    logic signed [MW-1:0] m [4];
    logic signed [SW-1:0] y0, y1;
    logic [OW-1:0] z0, z1;
    logic ov;
    logic v1, v2, adv;
    assign adv = !s.out_valid | s.out_ready;
    assign s.in_ready = adv;
    assign s.busy = v1 | v2 | s.out_valid;
    assign s.flt_ready = !s.busy & !s.in_valid;
    always_comb begin
        for (int i = 0; i < 4; i++) d[i] = s.in_d[(4-i)*DW-1 -: DW];
        for (int i = 0; i < 3; i++) f[i] = s.flt_g[(3-i)*GW-1 -: GW];
        tn[0] = TW'(d[0]) - TW'(d[2]);
        tn[1] = TW'(d[1]) + TW'(d[2]);
        tn[2] = TW'(d[2]) - TW'(d[1]);
        tn[3] = TW'(d[1]) - TW'(d[3]);
        // both sums are even because the filter transform was scaled by 2
        y0 = (SW'(m[0]) + SW'(m[1]) + SW'(m[2])) >>> 1;
        y1 = (SW'(m[1]) - SW'(m[2]) - SW'(m[3])) >>> 1;
    end
`ifdef SATURATE_EN
    logic o0, o1;
    always_comb begin
        o0 = !(&y0[SW-1:OW-1] | ~|y0[SW-1:OW-1]);
        o1 = !(&y1[SW-1:OW-1] | ~|y1[SW-1:OW-1]);
        z0 = o0 ? {y0[SW-1], {(OW-1){~y0[SW-1]}}} : y0[OW-1:0];
        z1 = o1 ? {y1[SW-1], {(OW-1){~y1[SW-1]}}} : y1[OW-1:0];
        ov = o0 | o1;
    end
`else
    logic unused_bits;
    assign z0 = y0[OW-1:0];
    assign z1 = y1[OW-1:0];
    assign ov = 1'b0;
    assign unused_bits = ^{y0[SW-1:OW], y1[SW-1:OW], ov};
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            s.out_valid <= 1'b0;
            s.out_z <= '0;
            s.ovf <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                t[i] <= '0;
                g[i] <= '0;
                m[i] <= '0;
            end
        end else begin
            if (s.flt_load & s.flt_ready) begin
                g[0] <= FW'(f[0]) + FW'(f[0]);
                g[1] <= FW'(f[0]) + FW'(f[1]) + FW'(f[2]);
                g[2] <= FW'(f[0]) - FW'(f[1]) + FW'(f[2]);
                g[3] <= FW'(f[2]) + FW'(f[2]);
            end
            if (adv) begin
                v1 <= s.in_valid;
                v2 <= v1;
                s.out_valid <= v2;
                for (int i = 0; i < 4; i++) begin
                    t[i] <= tn[i];
                    m[i] <= MW'(t[i]) * MW'(g[i]);
                end
                if (v2) s.out_z <= {z0, z1};
`ifdef SATURATE_EN
                if (v2 & ov) s.ovf <= 1'b1;
`else
                s.ovf <= 1'b0;
`endif
            end
        end
    end
endmodule
